// File: rtl/regfile_wb_sweep.sv
// regfile_wb_sweep: 2-read/1-write register file for the decode stage.
//   - Registered write-back stage: a request captured at one edge commits at the next.
//   - Index 0 is hard zero.
//   - Mailbox input writes IN_IDX directly and wins over a colliding WB commit.
//   - mbox_out is a registered mirror of reg[OUT_IDX].
//   - clr_req starts a sweep that zeroes one index per cycle while clr_busy is high.
// Optional feature macro: BYPASS_EN (read-port forwarding from the mailbox and WB stage).
//
// state | meaning
// IDLE  | normal operation, WB capture and mailbox writes accepted
// SWEEP | zeroing index sweep_idx this cycle, new requests dropped
module regfile_wb_sweep #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int LINK_IDX = 31,
  parameter int IN_IDX   = 25,
  parameter int OUT_IDX  = 24
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wb_en,
  input  logic              wb_link,
  input  logic              wb_regdst,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic              wb_memtoreg,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] link_pc,
  input  logic              mbox_in_vld,
  input  logic [DATA_W-1:0] mbox_in,
  output logic [DATA_W-1:0] mbox_out,
  input  logic              clr_req,
  output logic              clr_busy
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_A   = ADDR_W'(LINK_IDX);
  localparam logic [ADDR_W-1:0] IN_A     = ADDR_W'(IN_IDX);
  localparam logic [ADDR_W-1:0] OUT_A    = ADDR_W'(OUT_IDX);
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              wb_vld;
  logic [ADDR_W-1:0] wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic [ADDR_W-1:0] sweep_idx;
  logic              idle;
  logic              wb_req;
  logic              mbox_wr;

  assign idle    = (state == IDLE);
  assign wb_req  = idle & (wb_en | wb_link);
  assign mbox_wr = idle & mbox_in_vld & (IN_A != '0);

  // Array, WB stage, mailbox mirror and clear sequencer; later writes to the same index win.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= IDLE;
      clr_busy  <= 1'b0;
      sweep_idx <= '0;
      wb_vld    <= 1'b0;
      wb_dest   <= '0;
      wb_data   <= '0;
      mbox_out  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      mbox_out <= mem[OUT_A];

      if (wb_vld && (wb_dest != '0)) mem[wb_dest] <= wb_data;
      if (mbox_wr) mem[IN_A] <= mbox_in;

      wb_vld <= wb_req;
      if (wb_req) begin
        if (wb_link) begin
          wb_dest <= LINK_A;
          wb_data <= link_pc;
        end else begin
          wb_dest <= wb_regdst ? rd_addr : rt_addr;
          wb_data <= wb_memtoreg ? mem_data : alu_result;
        end
      end

      case (state)
        IDLE: begin
          if (clr_req) begin
            state     <= SWEEP;
            clr_busy  <= 1'b1;
            sweep_idx <= '0;
          end
        end
        SWEEP: begin
          mem[sweep_idx] <= '0;
          sweep_idx      <= sweep_idx + 1'b1;
          if (sweep_idx == LAST_IDX) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
        end
      endcase
    end
  end

  // Read port A: hard zero at index 0, optional forwarding of in-flight writes.
  always_comb begin
    rs_data = mem[rs_addr];
`ifdef BYPASS_EN
    if (wb_vld && (wb_dest == rs_addr)) rs_data = wb_data;
    if (mbox_wr && (rs_addr == IN_A)) rs_data = mbox_in;
`endif
    if (rs_addr == '0) rs_data = '0;
  end

  // Read port B: same rules as port A.
  always_comb begin
    rt_data = mem[rt_addr];
`ifdef BYPASS_EN
    if (wb_vld && (wb_dest == rt_addr)) rt_data = wb_data;
    if (mbox_wr && (rt_addr == IN_A)) rt_data = mbox_in;
`endif
    if (rt_addr == '0) rt_data = '0;
  end

endmodule
